// File: rtl/dct_coeff_serializer_if.sv
// dct_coeff_serializer_if
//   Bundles the two handshakes of the DCT coefficient serializer.
//   Block side: the DCT core hands over a complete N-coefficient block.
//   Beat side: one coefficient per beat goes to the downstream consumer.
// Signals
//   in_valid  core presents a full block on in_data
//   in_ready  serializer can take a block this cycle
//   in_data   N*W block, coefficient k in in_data[k*W +: W]
//   out_valid out_data/out_idx/out_last carry a valid beat
//   out_ready downstream takes the beat this cycle
//   out_data  current coefficient (W bits, two's complement)
//   out_idx   position of out_data within its block
//   out_last  final coefficient of a block
// Modports
//   master  the environment: drives the block and the beat acceptance
//   slave   the serializer itself
interface dct_coeff_serializer_if #(
    parameter int W = 16,
    parameter int N = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [N*W-1:0]      in_data;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_data;
    logic [2:0]          out_idx;
    logic                out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/dct_coeff_serializer.sv
// dct_coeff_serializer
//   Output end of the 1D DCT datapath. Takes one 8-point coefficient block
//   in parallel and streams it out one coefficient per beat, index 0 first.
//   A two-slot ping-pong buffer lets the core deliver the next block while
//   the current one drains, so with out_ready held high the beats run back
//   to back across block boundaries.
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-low; clears occupancy, pointers and index
//   bus    dct_coeff_serializer_if.slave (block in, coefficient beats out)
module dct_coeff_serializer #(
    parameter int W = 16,
    parameter int N = 8
) (
    input logic                  clk,
    input logic                  reset,
    dct_coeff_serializer_if.slave bus
);
    localparam logic [2:0] LAST_IDX = 3'(N - 1);

    logic [1:0]     cnt;
    logic           wr_ptr;
    logic           rd_ptr;
    logic [2:0]     idx;
    logic [N*W-1:0] slot_0;
    logic [N*W-1:0] slot_1;
    logic [N*W-1:0] rd_word;
    logic signed [W-1:0] cur_coeff;

    logic accept;
    logic beat;
    logic final_beat;

    // in_ready depends on registered occupancy only, so out_ready never
    // reaches it combinationally; a slot freed by a final beat becomes
    // writable on the following cycle.
    assign bus.in_ready  = (cnt != 2'd2);
    assign bus.out_valid = (cnt != 2'd0);

    assign accept     = bus.in_valid && bus.in_ready;
    assign beat       = bus.out_valid && bus.out_ready;
    assign final_beat = beat && (idx == LAST_IDX);

    // Control state: occupancy, ping-pong pointers and beat index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            idx    <= 3'd0;
        end else begin
            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end
            if (beat) begin
                if (idx == LAST_IDX) begin
                    idx    <= 3'd0;
                    rd_ptr <= ~rd_ptr;
                end else begin
                    idx <= idx + 3'd1;
                end
            end
            // Accept and final beat together leave the occupancy unchanged.
            case ({accept, final_beat})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Slot storage carries no reset: an empty slot is never read, because
    // out_valid masks the output until a block has been written.
    // With one block draining, wr_ptr already points at the other slot, so
    // the block being read out is never overwritten.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (wr_ptr) begin
                slot_1 <= bus.in_data;
            end else begin
                slot_0 <= bus.in_data;
            end
        end
    end

    assign rd_word   = rd_ptr ? slot_1 : slot_0;
    assign cur_coeff = rd_word[int'(idx)*W +: W];

    assign bus.out_data = bus.out_valid ? cur_coeff : '0;
    assign bus.out_idx  = bus.out_valid ? idx : 3'd0;
    assign bus.out_last = bus.out_valid && (idx == LAST_IDX);
endmodule
